// File: rtl/md_pkg.sv
// Shared constants for the MiniSys-1A multiply/divide sequencer:
// operation codes, the ALU function codes it drives, and the controller states.
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [3:0] ALU_ADDU = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    LOOP,
    FIX_LO,
    FIX_HI,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared 32-bit ALU
// for shift-add multiply and restoring divide, and owns the HI/LO registers.
module muldiv_seq
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_q,
  input  logic        alu_cf
);

  state_t      state, state_n;
  logic [31:0] a_reg, b_reg;
  logic [4:0]  cnt;
  logic        is_div, sa, sb, z;
  logic        op_signed, op_is_div, accept, neg_hi;

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_is_div = (op == MD_DIV)  || (op == MD_DIVU);
  assign accept    = hi[31] | alu_cf;
  assign neg_hi    = is_div ? sa : (sa ^ sb);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign alu_own = busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    case (state)
      IDLE: if (start) state_n = NEG_A;
      NEG_A: begin
        alu_control = sa ? ALU_SUBU : ALU_ADDU;
        alu_a       = sa ? '0 : a_reg;
        alu_b       = sa ? a_reg : '0;
        state_n     = NEG_B;
      end
      NEG_B: begin
        alu_control = sb ? ALU_SUBU : ALU_ADDU;
        alu_a       = sb ? '0 : b_reg;
        alu_b       = sb ? b_reg : '0;
        state_n     = LOOP;
      end
      LOOP: begin
        if (is_div) begin
          alu_control = ALU_SUBU;
          alu_a       = {hi[30:0], lo[31]};
          alu_b       = b_reg;
        end else begin
          alu_control = ALU_ADDU;
          alu_a       = hi;
          alu_b       = lo[0] ? a_reg : '0;
        end
        if (cnt == 5'd0) state_n = FIX_LO;
      end
      FIX_LO: begin
        alu_control = (sa ^ sb) ? ALU_SUBU : ALU_ADDU;
        alu_a       = (sa ^ sb) ? '0 : lo;
        alu_b       = (sa ^ sb) ? lo : '0;
        state_n     = FIX_HI;
      end
      FIX_HI: begin
        // A signed product with a nonzero low word only needs a ones' complement high word
        if (neg_hi && !is_div && !z) begin
          alu_control = ALU_NOR;
          alu_a       = hi;
        end else if (neg_hi) begin
          alu_control = ALU_SUBU;
          alu_b       = hi;
        end else begin
          alu_control = ALU_ADDU;
          alu_a       = hi;
        end
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      dbz    <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      z      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= src_a;
            b_reg  <= src_b;
            is_div <= op_is_div;
            sa     <= op_signed & src_a[31];
            sb     <= op_signed & src_b[31];
            dbz    <= 1'b0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        NEG_A: a_reg <= alu_q;
        NEG_B: begin
          hi  <= '0;
          cnt <= 5'd31;
          if (is_div) begin
            lo    <= a_reg;
            b_reg <= alu_q;
            dbz   <= (alu_q == 32'd0);
          end else begin
            lo <= alu_q;
          end
        end
        LOOP: begin
          cnt <= cnt - 5'd1;
          if (is_div) begin
            hi <= accept ? alu_q : {hi[30:0], lo[31]};
            lo <= {lo[30:0], accept};
          end else begin
            hi <= {alu_cf, alu_q[31:1]};
            lo <= {alu_q[0], lo[31:1]};
          end
        end
        FIX_LO: begin
          lo <= alu_q;
          z  <= (lo == 32'd0);
        end
        FIX_HI: hi <= alu_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural stand-in for alu_32.
module tb_muldiv_seq;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op_sel;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, dbz, alu_own, alu_cf;
  logic [31:0] hi, lo, alu_a, alu_b, alu_q;
  logic [3:0]  alu_control;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op_sel),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_q(alu_q), .alu_cf(alu_cf)
  );

  // Stand-in for alu_32: carry after SUBU means no borrow
  always_comb begin
    alu_q  = '0;
    alu_cf = 1'b0;
    case (alu_control)
      ALU_ADDU: {alu_cf, alu_q} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUBU: begin
        alu_q  = alu_a - alu_b;
        alu_cf = (alu_a >= alu_b);
      end
      ALU_NOR:  alu_q = ~(alu_a | alu_b);
      default:  ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Launches one operation, optionally disturbing it, and checks timing and results
  task automatic applyStimulus(input string tag, input logic [1:0] op_code,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic exp_dbz, input bit write_with_start,
                               input int write_cyc, input int start_cyc);
    int done_cyc = 0;
    int busy_cnt = 0;
    int own_err  = 0;
    logic [31:0] got_hi = '0;
    logic [31:0] got_lo = '0;
    logic        got_dbz = 1'b0;
    @(negedge clk);
    op_sel = op_code;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    if (write_with_start) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hDEADBEEF;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (alu_own !== busy) own_err++;
      if (done) begin
        done_cyc = cyc;
        got_hi   = hi;
        got_lo   = lo;
        got_dbz  = dbz;
        break;
      end
      hi_we = (cyc == write_cyc);
      lo_we = (cyc == write_cyc);
      wdata = 32'h12345678;
      start = (cyc == start_cyc);
      if (cyc == start_cyc) begin
        op_sel = MD_DIVU;
        src_a  = 32'h00000009;
        src_b  = 32'h00000002;
      end
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput({tag, " done cycle"}, done_cyc, 37);
    checkOutput({tag, " busy cycles"}, busy_cnt, 37);
    checkOutput({tag, " alu_own"}, own_err, 0);
    checkOutput({tag, " hi"}, got_hi, exp_hi);
    checkOutput({tag, " lo"}, got_lo, exp_lo);
    checkOutput({tag, " dbz"}, got_dbz, exp_dbz);
    @(negedge clk);
    checkOutput({tag, " done pulse"}, {done, busy}, 2'b00);
    checkOutput({tag, " alu idle"}, {alu_a, alu_b, alu_control}, 68'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op_sel = '0; src_a = '0; src_b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset status", {busy, done, dbz, alu_own}, 4'b0000);
    checkOutput("reset hi/lo", {hi, lo}, 64'd0);
    checkOutput("reset alu", {alu_a, alu_b, alu_control}, 68'd0);
    rst = 1'b0;

    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    lo_we = 1'b0;
    checkOutput("mthi/mtlo", {hi, lo}, 64'hA5A5A5A5_5A5A5A5A);

    applyStimulus("multu 3x5", MD_MULTU, 32'h3, 32'h5, 32'h0, 32'hF, 1'b0, 1'b1, 0, 0);
    applyStimulus("mult -2x3", MD_MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA,
                  1'b0, 1'b0, 0, 0);
    applyStimulus("multu max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
                  32'h00000001, 1'b0, 1'b0, 0, 0);
    applyStimulus("divu 100/7", MD_DIVU, 32'h64, 32'h7, 32'h2, 32'hE, 1'b0, 1'b0, 0, 0);
    applyStimulus("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD,
                  1'b0, 1'b0, 0, 0);
    applyStimulus("divu 10/0", MD_DIVU, 32'hA, 32'h0, 32'hA, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput("dbz held", dbz, 1'b1);
    applyStimulus("div min/-1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000,
                  1'b0, 1'b0, 0, 0);
    applyStimulus("div -8/0", MD_DIV, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFF8, 32'h00000001,
                  1'b1, 1'b0, 0, 0);
    applyStimulus("busy ignore", MD_MULT, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA,
                  1'b0, 1'b0, 5, 10);

    // Abort a divide partway through with reset
    @(negedge clk);
    op_sel = MD_DIV; src_a = 32'h64; src_b = 32'h7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort state", {busy, done, dbz}, 3'b000);
    checkOutput("abort hi/lo", {hi, lo}, 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checkOutput("abort no done", seen_done, 0);
    applyStimulus("multu 2x2", MD_MULTU, 32'h2, 32'h2, 32'h0, 32'h4, 1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for MiniSys-1A MULT/MULTU/DIV/DIVU. Executes shift-add multiply and restoring divide by time-sharing the existing 32-bit ALU (`alu_32`) through an operand/control mux, and owns the HI/LO registers. It sits beside the execute stage. The pipeline stalls while `busy` is high, and the ALU is driven by this block while `alu_own` is high.

## Interface
Parameters: none (width fixed at 32).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch operation; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `src_a`, `src_b`  in  32  rs (multiplicand/dividend), rt (multiplier/divisor)
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse; HI/LO final
- `dbz`  out  1  divide-by-zero flag; valid with `done`, held until next start
- `hi`, `lo`  out  32  HI/LO registers
- `alu_own`  out  1  controller owns ALU (= `busy`)
- `alu_a`, `alu_b`  out  32  ALU operands
- `alu_control`  out  4  ALU op: ADDU 0110, SUBU 1011, NOR 0100
- `alu_q`  in  32  ALU result
- `alu_cf`  in  1  ALU carry. After SUBU, 1 means no borrow (a ≥ b unsigned).

## Operation
- Reset: state IDLE; `hi`, `lo`, `dbz`, `done`, `busy`, `alu_own` = 0; `alu_a`/`alu_b`/`alu_control` = 0.
- IDLE:
  - `start` latches `op`, `src_a`, `src_b`, and records `sa = src_a[31]` and `sb = src_b[31]` (both forced 0 for unsigned ops). Next state NEG_A.
  - Otherwise `hi_we`/`lo_we` write `wdata`.
  - `start` together with a write: start wins, write dropped.
  - Writes and `start` are ignored whenever not IDLE.
- NEG_A: if `sa`, A ← SUBU(0, A), else ADDU(A, 0). Next NEG_B.
- NEG_B: same for B with `sb`. Load for multiply: hi ← 0, lo ← |B|, M ← |A|. Load for divide: hi ← 0 (remainder R), lo ← |A|, D ← |B|, `dbz` ← (B == 0). Next LOOP, counter ← 31.
- LOOP (32 cycles, counter down to 0):
  - Multiply: ALU ADDU(hi, lo[0] ? M : 0); {hi, lo} ← {alu_cf, alu_q, lo[31:1]}.
  - Divide: T = {R[30:0], lo[31]}, ALU SUBU(T, D); accept = R[31] | alu_cf; R ← accept ? alu_q : T; lo ← {lo[30:0], accept}.
  - Exit to FIX_LO at counter 0.
- FIX_LO:
  - Multiply: if `sa ^ sb`, lo ← SUBU(0, lo), and store z = (lo == 0) before update.
  - Divide: negate lo if `sa ^ sb`.
  - Otherwise pass via ADDU(x, 0).
- FIX_HI:
  - Multiply, if `sa ^ sb`: hi ← z ? SUBU(0, hi) : NOR(hi, 0).
  - Divide, if `sa`: hi ← SUBU(0, hi).
  - Else pass.
  - Next DONE.
- DONE: `done` = 1 for one cycle; next IDLE.
- Divide by zero: algorithm runs unchanged. DIVU gives lo = FFFFFFFF, hi = src_a. DIV gives hi = src_a and lo = FFFFFFFF if src_a ≥ 0, else 00000001.
- DIV 80000000 / FFFFFFFF: lo = 80000000, hi = 0, no flag.
- Outside of `busy`, `alu_a`/`alu_b`/`alu_control` hold 0 and the execute-stage mux selects the pipeline operands.

## Timing
- Fixed latency regardless of operands.
- `start` sampled at edge 0. `busy` is high for 37 cycles (NEG_A, NEG_B, 32× LOOP, FIX_LO, FIX_HI, DONE).
- `done` is high in cycle 37 after the start edge, with `hi`/`lo` already final. A new `start` is accepted in the cycle after DONE (IDLE).
- The ALU is purely combinational inside one cycle. ALU outputs are registered into hi/lo/R each cycle, with no extra ALU latency.
- `rst` mid-operation: at the next edge go to IDLE, clear `hi`/`lo`/`dbz`, drop the operation, and emit no `done`.

## Structure
- Package `md_pkg`: op codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), ALU codes (ALU_ADDU = 4'b0110, ALU_SUBU = 4'b1011, ALU_NOR = 4'b0100), state enum (IDLE, NEG_A, NEG_B, LOOP, FIX_LO, FIX_HI, DONE).
- Single module with no sub-module. `alu_32` and the execute-stage operand mux are instantiated by the parent.

## Test plan
- MULTU 00000003 × 00000005 → `done` at cycle 37; hi = 0, lo = 0000000F; `busy` high 37 cycles.
- MULT FFFFFFFE × 00000003 → hi = FFFFFFFF, lo = FFFFFFFA. MULTU FFFFFFFF × FFFFFFFF → hi = FFFFFFFE, lo = 00000001.
- DIVU 00000064 / 00000007 → lo = 0000000E, hi = 00000002. DIV FFFFFFF9 / 00000002 → lo = FFFFFFFD, hi = FFFFFFFF.
- DIVU 0000000A / 0 → `dbz` = 1, lo = FFFFFFFF, hi = 0000000A. DIV 80000000 / FFFFFFFF → lo = 80000000, hi = 0.
- MTHI 12345678 while busy, and a second `start` at cycle 10 → both ignored; the original result is unchanged.
- `rst` at cycle 20 of DIV → next cycle `busy` = 0, hi = lo = 0, no `done` pulse. A following MULTU 2 × 2 → lo = 4.
